// File: rtl/ram_sp_req_bridge_if.sv
// Request/response/RAM-control bundle for ram_sp_req_bridge.
// Signal names keep the bridge's point of view (i_ = into bridge, o_ = out of bridge).
interface ram_sp_req_bridge_if #(
    parameter int WORD_BIT_WIDTH = 32,
    parameter int DEPTH          = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = WORD_BIT_WIDTH / 8;

    logic                      i_req_valid;
    logic                      o_req_ready;
    logic                      i_req_we;
    logic [AW-1:0]             i_req_word_addr;
    logic [WORD_BIT_WIDTH-1:0] i_req_data;
    logic [BW-1:0]             i_req_byte_en;

    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic                      o_rsp_is_wr;
    logic [WORD_BIT_WIDTH-1:0] o_rsp_data;

    logic                      o_ram_we;
    logic [AW-1:0]             o_ram_word_addr;
    logic [WORD_BIT_WIDTH-1:0] o_ram_data;
    logic [BW-1:0]             o_ram_wr_byte_en;
    logic [WORD_BIT_WIDTH-1:0] i_ram_data;

    modport slave (
        input  i_req_valid, i_req_we, i_req_word_addr, i_req_data, i_req_byte_en,
        input  i_rsp_ready, i_ram_data,
        output o_req_ready, o_rsp_valid, o_rsp_is_wr, o_rsp_data,
        output o_ram_we, o_ram_word_addr, o_ram_data, o_ram_wr_byte_en
    );

    modport master (
        output i_req_valid, i_req_we, i_req_word_addr, i_req_data, i_req_byte_en,
        output i_rsp_ready, i_ram_data,
        input  o_req_ready, o_rsp_valid, o_rsp_is_wr, o_rsp_data,
        input  o_ram_we, o_ram_word_addr, o_ram_data, o_ram_wr_byte_en
    );
endinterface

// File: rtl/ram_sp_req_bridge.sv
// Valid/ready front-end for a single-port write-first RAM: one transaction in flight,
// registered RAM controls, read-latency tracking and a held response channel.
module ram_sp_req_bridge #(
    parameter int WORD_BIT_WIDTH = 32,
    parameter int DEPTH          = 8,
    parameter int READ_LATENCY   = 1
) (
    input  logic                 i_clk,
    input  logic                 i_sync_rst_n,
    ram_sp_req_bridge_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = WORD_BIT_WIDTH / 8;
    localparam logic [1:0] RD_WAIT = 2'(READ_LATENCY);

    if (WORD_BIT_WIDTH < 8 || (WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0) begin : g_bad_width
        $error("WORD_BIT_WIDTH must be a power of 2 and >= 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic                      op_we_q, op_we_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_is_wr_q, rsp_is_wr_d;
    logic [WORD_BIT_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                      ram_we_q, ram_we_d;
    logic [AW-1:0]             ram_addr_q, ram_addr_d;
    logic [WORD_BIT_WIDTH-1:0] ram_data_q, ram_data_d;
    logic [BW-1:0]             ram_be_q, ram_be_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_we_d     = op_we_q;
        rsp_valid_d = rsp_valid_q;
        rsp_is_wr_d = rsp_is_wr_q;
        rsp_data_d  = rsp_data_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_be_d    = ram_be_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req_valid) begin
                    ram_addr_d = bus.i_req_word_addr;
                    ram_data_d = bus.i_req_data;
                    ram_we_d   = bus.i_req_we;
                    ram_be_d   = bus.i_req_we ? bus.i_req_byte_en : '0;
                    op_we_d    = bus.i_req_we;
                    cnt_d      = bus.i_req_we ? 2'd1 : RD_WAIT;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                // The write strobe lives for exactly the accept cycle.
                ram_we_d = 1'b0;
                ram_be_d = '0;
                cnt_d    = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    rsp_valid_d = 1'b1;
                    rsp_is_wr_d = op_we_q;
                    rsp_data_d  = op_we_q ? '0 : bus.i_ram_data;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_sync_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            op_we_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_is_wr_q <= 1'b0;
            rsp_data_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_is_wr_q <= rsp_is_wr_d;
            rsp_data_q  <= rsp_data_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_be_q    <= ram_be_d;
        end
    end

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign bus.o_req_ready      = (state_q == S_IDLE) && i_sync_rst_n;
    assign bus.o_rsp_valid      = rsp_valid_q;
    assign bus.o_rsp_is_wr      = rsp_is_wr_q;
    assign bus.o_rsp_data       = rsp_data_q;
    assign bus.o_ram_we         = ram_we_q;
    assign bus.o_ram_word_addr  = ram_addr_q;
    assign bus.o_ram_data       = ram_data_q;
    assign bus.o_ram_wr_byte_en = ram_be_q;
endmodule

// File: tb/tb_ram_sp_req_bridge.sv
// Directed + random check of ram_sp_req_bridge; unit 0 uses READ_LATENCY=1, unit 1 uses 2,
// each with its own behavioural RAM.
module tb_ram_sp_req_bridge;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AW = 3;
    localparam int BW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          rst_n     [2];
    logic          req_valid [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [W-1:0]  req_data  [2];
    logic [BW-1:0] req_be    [2];
    logic          rsp_ready [2];

    wire [1:0]     req_ready;
    wire [1:0]     rsp_valid;
    wire [1:0]     rsp_is_wr;
    wire [1:0]     ram_we;
    wire [W-1:0]   rsp_data  [2];
    wire [AW-1:0]  ram_addr  [2];
    wire [W-1:0]   ram_wdata [2];
    wire [BW-1:0]  ram_be    [2];

    logic [W-1:0]  model [2][D];

    for (genvar gi = 0; gi < 2; gi++) begin : g_unit
        ram_sp_req_bridge_if #(.WORD_BIT_WIDTH(W), .DEPTH(D)) bus ();
        logic [W-1:0] mem [D];
        logic [W-1:0] rd_comb;
        logic [W-1:0] rd_q;

        assign bus.i_req_valid     = req_valid[gi];
        assign bus.i_req_we        = req_we[gi];
        assign bus.i_req_word_addr = req_addr[gi];
        assign bus.i_req_data      = req_data[gi];
        assign bus.i_req_byte_en   = req_be[gi];
        assign bus.i_rsp_ready     = rsp_ready[gi];
        assign req_ready[gi]       = bus.o_req_ready;
        assign rsp_valid[gi]       = bus.o_rsp_valid;
        assign rsp_is_wr[gi]       = bus.o_rsp_is_wr;
        assign rsp_data[gi]        = bus.o_rsp_data;
        assign ram_we[gi]          = bus.o_ram_we;
        assign ram_addr[gi]        = bus.o_ram_word_addr;
        assign ram_wdata[gi]       = bus.o_ram_data;
        assign ram_be[gi]          = bus.o_ram_wr_byte_en;

        always_ff @(posedge clk) begin
            if (bus.o_ram_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (bus.o_ram_wr_byte_en[b]) begin
                        mem[bus.o_ram_word_addr][b*8 +: 8] <= bus.o_ram_data[b*8 +: 8];
                    end
                end
            end
            rd_q <= rd_comb;
        end
        assign rd_comb        = mem[bus.o_ram_word_addr];
        assign bus.i_ram_data = (gi == 0) ? rd_comb : rd_q;

        ram_sp_req_bridge #(.WORD_BIT_WIDTH(W), .DEPTH(D), .READ_LATENCY(gi + 1)) u_dut (
            .i_clk        (clk),
            .i_sync_rst_n (rst_n[gi]),
            .bus          (bus)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on unit u: gap idle cycles, accept, wait for the response,
    // hold it under backpressure for 'hold' cycles, then handshake.
    task automatic txn(input int u, input bit we, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [BW-1:0] be, input int gap, input int hold,
                       output logic [W-1:0] rdata);
        logic [W-1:0] exp;
        int cyc;
        int lat;
        for (int i = 0; i < gap; i++) begin
            tick();
            chk("idle_ram_we", W'(ram_we[u]), 32'd0);
        end
        cyc = 0;
        while (!req_ready[u] && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("req_ready_before", W'(req_ready[u]), 32'd1);
        if (we) begin
            for (int b = 0; b < BW; b++) begin
                if (be[b]) model[u][a][b*8 +: 8] = d[b*8 +: 8];
            end
            exp = '0;
            lat = 1;
        end else begin
            exp = model[u][a];
            lat = u + 1;
        end
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_addr[u]  = a;
        req_data[u]  = d;
        req_be[u]    = be;
        rsp_ready[u] = (hold == 0);
        tick();
        req_valid[u] = 1'b0;
        req_data[u]  = $urandom();
        req_addr[u]  = AW'($urandom_range(0, D - 1));
        chk("ram_we_accept", W'(ram_we[u]), W'(we));
        chk("ram_addr_accept", W'(ram_addr[u]), W'(a));
        chk("ram_be_accept", W'(ram_be[u]), W'(we ? be : 4'h0));
        if (we) chk("ram_data_accept", ram_wdata[u], d);
        cyc = 0;
        do begin
            tick();
            cyc++;
            chk("ram_we_busy", W'(ram_we[u]), 32'd0);
            chk("ram_addr_busy", W'(ram_addr[u]), W'(a));
        end while (!rsp_valid[u] && cyc < 10);
        chk("rsp_latency", W'(cyc), W'(lat));
        chk("rsp_valid", W'(rsp_valid[u]), 32'd1);
        chk("rsp_is_wr", W'(rsp_is_wr[u]), W'(we));
        chk("rsp_data", rsp_data[u], exp);
        chk("req_ready_in_rsp", W'(req_ready[u]), 32'd0);
        rdata = rsp_data[u];
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_rsp_valid", W'(rsp_valid[u]), 32'd1);
            chk("bp_rsp_data", rsp_data[u], exp);
            chk("bp_req_ready", W'(req_ready[u]), 32'd0);
            chk("bp_ram_we", W'(ram_we[u]), 32'd0);
        end
        rsp_ready[u] = 1'b1;
        tick();
        rsp_ready[u] = 1'b0;
        chk("rsp_valid_after_hs", W'(rsp_valid[u]), 32'd0);
        chk("req_ready_after_hs", W'(req_ready[u]), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] r;
        for (int u = 0; u < 2; u++) begin
            rst_n[u]     = 1'b0;
            req_valid[u] = 1'b0;
            req_we[u]    = 1'b0;
            req_addr[u]  = '0;
            req_data[u]  = '0;
            req_be[u]    = '0;
            rsp_ready[u] = 1'b0;
            for (int a = 0; a < D; a++) model[u][a] = '0;
        end

        // Reset held for 5 cycles
        repeat (5) tick();
        for (int u = 0; u < 2; u++) begin
            chk("rst_req_ready", W'(req_ready[u]), 32'd0);
            chk("rst_rsp_valid", W'(rsp_valid[u]), 32'd0);
            chk("rst_rsp_is_wr", W'(rsp_is_wr[u]), 32'd0);
            chk("rst_rsp_data", rsp_data[u], 32'd0);
            chk("rst_ram_we", W'(ram_we[u]), 32'd0);
            chk("rst_ram_addr", W'(ram_addr[u]), 32'd0);
            chk("rst_ram_data", ram_wdata[u], 32'd0);
            chk("rst_ram_be", W'(ram_be[u]), 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();
        chk("ready_after_rst_u0", W'(req_ready[0]), 32'd1);
        chk("ready_after_rst_u1", W'(req_ready[1]), 32'd1);

        for (int u = 0; u < 2; u++) begin
            // Write then read back, latency checked inside txn
            txn(u, 1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 0, 0, r);
            chk("wr_ack_data", r, 32'h0);
            txn(u, 1'b0, 3'd3, 32'h0, 4'h0, 0, 0, r);
            chk("rd_deadbeef", r, 32'hDEADBEEF);

            // Byte-enable merge
            txn(u, 1'b1, 3'd5, 32'h11223344, 4'hF, 1, 0, r);
            txn(u, 1'b1, 3'd5, 32'hAABBCCDD, 4'b0101, 0, 0, r);
            txn(u, 1'b0, 3'd5, 32'h0, 4'h0, 0, 0, r);
            chk("be_merge", r, 32'h11BB33DD);

            // Response backpressure for 10 cycles
            txn(u, 1'b0, 3'd3, 32'h0, 4'h0, 0, 10, r);
            chk("bp_read", r, 32'hDEADBEEF);

            // Reset during a read of addr 2
            txn(u, 1'b1, 3'd2, 32'h0BADF00D, 4'hF, 0, 0, r);
            chk("mid_ready", W'(req_ready[u]), 32'd1);
            req_valid[u] = 1'b1;
            req_we[u]    = 1'b0;
            req_addr[u]  = 3'd2;
            rsp_ready[u] = 1'b1;
            tick();
            req_valid[u] = 1'b0;
            chk("mid_addr", W'(ram_addr[u]), 32'd2);
            rst_n[u] = 1'b0;
            tick();
            chk("mid_rst_ready", W'(req_ready[u]), 32'd0);
            chk("mid_rst_rsp_valid", W'(rsp_valid[u]), 32'd0);
            chk("mid_rst_ram_addr", W'(ram_addr[u]), 32'd0);
            tick();
            rst_n[u] = 1'b1;
            for (int i = 0; i < 6; i++) begin
                tick();
                chk("mid_no_rsp", W'(rsp_valid[u]), 32'd0);
            end
            rsp_ready[u] = 1'b0;
            txn(u, 1'b0, 3'd2, 32'h0, 4'h0, 0, 0, r);
            chk("mid_reread", r, 32'h0BADF00D);
        end

        // Fill every address so random reads never see unwritten RAM
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < D; a++) begin
                txn(u, 1'b1, AW'(a), 32'hC0DE0000 + W'(a), 4'hF, 0, 0, r);
            end
        end

        // Random stream against the scoreboard model
        for (int i = 0; i < 1000; i++) begin
            txn(i % 2, 1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)), $urandom(),
                BW'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3), r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
